// File: rtl/ascon_permutation_inv.sv
// Iterative inverse Ascon permutation: one inverse round per clock from index 11 down to 12-n.
// State word layout on the 320-bit ports: x0 = [319:256], x1 = [255:192], x2 = [191:128],
// x3 = [127:64], x4 = [63:0].
// Optional build macro ASCON_INV_SPLIT_EN: each inverse round takes two cycles (linear layer,
// then S-box + constant) to shorten the critical path; results are identical.
//
// state | meaning
// IDLE  | ready for a start request
// RUN   | applying inverse rounds, counter holds the current round index
// DONE  | one-cycle result strobe; a start here is accepted as in IDLE
module ascon_permutation_inv (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic         start_i,
  input  logic [3:0]   rounds_i,
  input  logic [319:0] state_i,
  output logic         ready_o,
  output logic         valid_o,
  output logic [319:0] state_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} fsm_e;

  localparam logic [4:0] INV_SBOX [32] = '{
    5'h14, 5'h1A, 5'h07, 5'h0D, 5'h00, 5'h09, 5'h0E, 5'h12,
    5'h0A, 5'h06, 5'h1D, 5'h01, 5'h19, 5'h15, 5'h13, 5'h1E,
    5'h18, 5'h16, 5'h0B, 5'h11, 5'h03, 5'h05, 5'h1C, 5'h1F,
    5'h17, 5'h1B, 5'h04, 5'h08, 5'h0F, 5'h0C, 5'h10, 5'h02
  };

  function automatic logic [63:0] ror64(input logic [63:0] x, input int s);
    // s == 0 makes the left shift go to zero, leaving x unchanged
    return (x >> s) | (x << (64 - s));
  endfunction

  // Sigma^-1 = Sigma^63, built as the product of Sigma^(2^k) for k = 0..5
  function automatic logic [63:0] inv_sigma(input logic [63:0] x, input int a, input int b);
    logic [63:0] y;
    y = x;
    for (int k = 0; k < 6; k++) begin
      y = y ^ ror64(y, ((1 << k) * a) % 64) ^ ror64(y, ((1 << k) * b) % 64);
    end
    return y;
  endfunction

  function automatic logic [319:0] inv_linear(input logic [319:0] s);
    return {inv_sigma(s[319:256], 19, 28), inv_sigma(s[255:192], 61, 39),
            inv_sigma(s[191:128], 1, 6),   inv_sigma(s[127:64], 10, 17),
            inv_sigma(s[63:0], 7, 41)};
  endfunction

  function automatic logic [319:0] inv_sbox_const(input logic [319:0] s, input logic [3:0] i);
    logic [319:0] r;
    logic [4:0]   col;
    logic [4:0]   o;
    r = '0;
    for (int j = 0; j < 64; j++) begin
      col = {s[256+j], s[192+j], s[128+j], s[64+j], s[j]};
      o   = INV_SBOX[col];
      r[256+j] = o[4];
      r[192+j] = o[3];
      r[128+j] = o[2];
      r[64+j]  = o[1];
      r[j]     = o[0];
    end
    r[135:128] = r[135:128] ^ {~i, i};
    return r;
  endfunction

  fsm_e         fsm_q, fsm_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [3:0]   lo_q, lo_d;
  logic [319:0] st_q, st_d;
  logic [3:0]   n_eff;
`ifdef ASCON_INV_SPLIT_EN
  logic         phase_q, phase_d;
`endif

  assign n_eff   = (rounds_i > 4'd12) ? 4'd12 : rounds_i;
  assign ready_o = (fsm_q != RUN);
  assign valid_o = (fsm_q == DONE);
  assign state_o = st_q;

  // Next-state: start acceptance, round datapath and round counter
  always_comb begin
    fsm_d = fsm_q;
    cnt_d = cnt_q;
    lo_d  = lo_q;
    st_d  = st_q;
`ifdef ASCON_INV_SPLIT_EN
    phase_d = phase_q;
`endif
    case (fsm_q)
      RUN: begin
`ifdef ASCON_INV_SPLIT_EN
        if (!phase_q) begin
          st_d    = inv_linear(st_q);
          phase_d = 1'b1;
        end else begin
          st_d    = inv_sbox_const(st_q, cnt_q);
          phase_d = 1'b0;
          if (cnt_q == lo_q) fsm_d = DONE;
          else               cnt_d = cnt_q - 4'd1;
        end
`else
        st_d = inv_sbox_const(inv_linear(st_q), cnt_q);
        if (cnt_q == lo_q) fsm_d = DONE;
        else               cnt_d = cnt_q - 4'd1;
`endif
      end
      default: begin
        // IDLE, DONE and any illegal encoding fall back to IDLE unless a start arrives
        fsm_d = IDLE;
        if (start_i) begin
          st_d  = state_i;
          cnt_d = 4'd11;
          lo_d  = 4'd12 - n_eff;
          fsm_d = (n_eff == 4'd0) ? DONE : RUN;
`ifdef ASCON_INV_SPLIT_EN
          phase_d = 1'b0;
`endif
        end
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      fsm_q <= IDLE;
      cnt_q <= 4'd0;
      lo_q  <= 4'd0;
      st_q  <= '0;
`ifdef ASCON_INV_SPLIT_EN
      phase_q <= 1'b0;
`endif
    end else begin
      fsm_q <= fsm_d;
      cnt_q <= cnt_d;
      lo_q  <= lo_d;
      st_q  <= st_d;
`ifdef ASCON_INV_SPLIT_EN
      phase_q <= phase_d;
`endif
    end
  end

endmodule

// File: tb/tb_ascon_permutation_inv.sv
// Bench for ascon_permutation_inv: forward Ascon reference model, round-trip and protocol checks.
module tb_ascon_permutation_inv;

  logic         clock_i = 1'b0;
  logic         reset_i;
  logic         start_i;
  logic [3:0]   rounds_i;
  logic [319:0] state_i;
  logic         ready_o;
  logic         valid_o;
  logic [319:0] state_o;

  int n_cmp = 0;
  int n_bad = 0;

  ascon_permutation_inv dut (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .start_i (start_i),
    .rounds_i(rounds_i),
    .state_i (state_i),
    .ready_o (ready_o),
    .valid_o (valid_o),
    .state_o (state_o)
  );

  always #5 clock_i = ~clock_i;

  logic [4:0] fwd_sbox [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };
  int rot_a [5] = '{19, 61, 1, 10, 7};
  int rot_b [5] = '{28, 39, 6, 17, 41};

  function automatic logic [63:0] rot(input logic [63:0] x, input int s);
    return (x >> s) | (x << (64 - s));
  endfunction

  // Forward Ascon round: constant, S-box, linear layer
  function automatic logic [319:0] fwd_round(input logic [319:0] s, input int i);
    logic [63:0]  x [5];
    logic [63:0]  y [5];
    logic [4:0]   v;
    logic [319:0] r;
    int c;
    for (int w = 0; w < 5; w++) x[w] = s[319-64*w -: 64];
    c = 240 - 15 * i;
    x[2] = x[2] ^ 64'(c);
    for (int j = 0; j < 64; j++) begin
      v = {x[0][j], x[1][j], x[2][j], x[3][j], x[4][j]};
      v = fwd_sbox[v];
      for (int w = 0; w < 5; w++) y[w][j] = v[4-w];
    end
    r = '0;
    for (int w = 0; w < 5; w++)
      r[319-64*w -: 64] = y[w] ^ rot(y[w], rot_a[w]) ^ rot(y[w], rot_b[w]);
    return r;
  endfunction

  function automatic logic [319:0] fwd_perm(input logic [319:0] s, input int n);
    logic [319:0] r;
    r = s;
    for (int i = 12 - n; i <= 11; i++) r = fwd_round(r, i);
    return r;
  endfunction

  function automatic logic [319:0] rand_state();
    logic [319:0] r;
    for (int k = 0; k < 10; k++) r[32*k +: 32] = $urandom();
    return r;
  endfunction

  function automatic int exp_lat(input int n);
`ifdef ASCON_INV_SPLIT_EN
    return 2 * n + 1;
`else
    return n + 1;
`endif
  endfunction

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  // Issue one start in the current cycle and wait (bounded) for valid_o; lat = -1 on timeout
  task automatic do_op(input logic [319:0] s, input logic [3:0] n,
                       output logic [319:0] res, output int lat);
    state_i  = s;
    rounds_i = n;
    start_i  = 1'b1;
    tick();
    start_i = 1'b0;
    lat = 1;
    while (!valid_o && lat < 60) begin
      tick();
      lat++;
    end
    if (!valid_o) lat = -1;
    res = state_o;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    start_i = 1'b0;
    rounds_i = 4'd0;
    state_i = rand_state();
    repeat (3) tick();
    reset_i = 1'b0;
    tick();
    n_cmp++; if (ready_o !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b exp=1", ready_o); end
    n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
    n_cmp++; if (state_o !== 320'd0) begin n_bad++; $display("FAIL reset_state got=%h exp=0", state_o); end
  endtask

  task automatic test_single_round();
    logic [319:0] res, exp_s;
    int lat;
    exp_s = {64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'hFFFF_FFFF_FFFF_FFB4, 64'h0, 64'h0};
    do_op(320'd0, 4'd1, res, lat);
    n_cmp++; if (lat != exp_lat(1)) begin n_bad++; $display("FAIL single_lat got=%0d exp=%0d", lat, exp_lat(1)); end
    n_cmp++; if (res !== exp_s) begin n_bad++; $display("FAIL single_state got=%h exp=%h", res, exp_s); end
    tick();
    n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL single_pulse got=%b exp=0", valid_o); end
    n_cmp++; if (state_o !== exp_s) begin n_bad++; $display("FAIL single_hold got=%h exp=%h", state_o, exp_s); end
  endtask

  task automatic test_round_trip();
    int ns [4] = '{1, 6, 8, 12};
    logic [319:0] orig, res;
    int lat;
    for (int t = 0; t < 4; t++) begin
      for (int r = 0; r < 3; r++) begin
        orig = rand_state();
        do_op(fwd_perm(orig, ns[t]), 4'(ns[t]), res, lat);
        n_cmp++; if (lat != exp_lat(ns[t])) begin n_bad++; $display("FAIL rt_lat n=%0d got=%0d exp=%0d", ns[t], lat, exp_lat(ns[t])); end
        n_cmp++; if (res !== orig) begin n_bad++; $display("FAIL rt_state n=%0d got=%h exp=%h", ns[t], res, orig); end
        tick();
      end
    end
  endtask

  task automatic test_bounds();
    logic [319:0] orig, res;
    int lat;
    orig = rand_state();
    do_op(orig, 4'd0, res, lat);
    n_cmp++; if (lat != 1) begin n_bad++; $display("FAIL n0_lat got=%0d exp=1", lat); end
    n_cmp++; if (res !== orig) begin n_bad++; $display("FAIL n0_state got=%h exp=%h", res, orig); end
    tick();
    orig = rand_state();
    do_op(fwd_perm(orig, 12), 4'd15, res, lat);
    n_cmp++; if (lat != exp_lat(12)) begin n_bad++; $display("FAIL n15_lat got=%0d exp=%0d", lat, exp_lat(12)); end
    n_cmp++; if (res !== orig) begin n_bad++; $display("FAIL n15_state got=%h exp=%h", res, orig); end
    tick();
  endtask

  task automatic test_start_held();
    logic [319:0] orig, res;
    int L, pulses, first;
    L = exp_lat(6);
    orig = rand_state();
    state_i  = fwd_perm(orig, 6);
    rounds_i = 4'd6;
    start_i  = 1'b1;
    tick();
    pulses = 0;
    first = 0;
    res = '0;
    for (int cyc = 1; cyc <= L + 6; cyc++) begin
      if (valid_o) begin
        pulses++;
        if (first == 0) begin first = cyc; res = state_o; end
      end
      if (cyc >= L - 1) start_i = 1'b0;
      else begin
        state_i  = rand_state();
        rounds_i = 4'($urandom_range(0, 15));
      end
      tick();
    end
    n_cmp++; if (pulses != 1) begin n_bad++; $display("FAIL held_pulses got=%0d exp=1", pulses); end
    n_cmp++; if (first != L) begin n_bad++; $display("FAIL held_lat got=%0d exp=%0d", first, L); end
    n_cmp++; if (res !== orig) begin n_bad++; $display("FAIL held_state got=%h exp=%h", res, orig); end
  endtask

  task automatic test_back_to_back();
    logic [319:0] a, b, res;
    int lat;
    a = rand_state();
    b = rand_state();
    do_op(fwd_perm(a, 3), 4'd3, res, lat);
    n_cmp++; if (lat != exp_lat(3)) begin n_bad++; $display("FAIL b2b_lat1 got=%0d exp=%0d", lat, exp_lat(3)); end
    n_cmp++; if (res !== a) begin n_bad++; $display("FAIL b2b_state1 got=%h exp=%h", res, a); end
    n_cmp++; if (ready_o !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_done got=%b exp=1", ready_o); end
    do_op(fwd_perm(b, 5), 4'd5, res, lat);
    n_cmp++; if (lat != exp_lat(5)) begin n_bad++; $display("FAIL b2b_lat2 got=%0d exp=%0d", lat, exp_lat(5)); end
    n_cmp++; if (res !== b) begin n_bad++; $display("FAIL b2b_state2 got=%h exp=%h", res, b); end
    tick();
  endtask

  task automatic test_reset_mid_run();
    int pulses;
    state_i  = rand_state();
    rounds_i = 4'd12;
    start_i  = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (4) tick();
    n_cmp++; if (ready_o !== 1'b0) begin n_bad++; $display("FAIL abort_busy got=%b exp=0", ready_o); end
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    n_cmp++; if (ready_o !== 1'b1) begin n_bad++; $display("FAIL abort_ready got=%b exp=1", ready_o); end
    n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL abort_valid got=%b exp=0", valid_o); end
    n_cmp++; if (state_o !== 320'd0) begin n_bad++; $display("FAIL abort_state got=%h exp=0", state_o); end
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      if (valid_o) pulses++;
      tick();
    end
    n_cmp++; if (pulses != 0) begin n_bad++; $display("FAIL abort_pulses got=%0d exp=0", pulses); end
  endtask

  initial begin
    reset_i  = 1'b1;
    start_i  = 1'b0;
    rounds_i = 4'd0;
    state_i  = '0;
    test_reset();
    test_single_round();
    test_round_trip();
    test_bounds();
    test_start_held();
    test_back_to_back();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
